// File: rtl/dlfloat_link_host.sv
// Host side of the MAC tile link: serialises DLFloat16 operand pairs as A/B words
// and reassembles tagged 16-bit results from the high/low byte stream.
module dlfloat_link_host #(
  parameter int LAT     = 6,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               op_valid,
  input  logic [15:0]        op_a,
  input  logic [15:0]        op_b,
  output logic               op_ready,
  output logic [15:0]        link_data,
  input  logic [7:0]         link_byte,
  output logic               res_valid,
  output logic [15:0]        res_data,
  output logic               busy,
  output logic [COUNT_W-1:0] tx_count,
  output logic [COUNT_W-1:0] rx_count
);

  localparam int OUT_W = $clog2(LAT / 2 + 2);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(LAT / 2);

  logic             slot;
  logic [15:0]      b_hold;
  logic [7:0]       hi_byte;
  logic [LAT-1:0]   tag;
  logic [OUT_W-1:0] outstanding;
  logic             accept;
  logic             deliver;

  assign op_ready = enable & slot & (outstanding < OUT_MAX);
  assign accept   = op_valid & op_ready;
  // tag[LAT-1] holds the flag pushed LAT edges ago; LAT even keeps it on a slot=1 edge
  assign deliver  = slot & tag[LAT-1];
  assign busy     = (outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot        <= 1'b0;
      link_data   <= 16'h0000;
      b_hold      <= 16'h0000;
      hi_byte     <= 8'h00;
      tag         <= '0;
      res_valid   <= 1'b0;
      res_data    <= 16'h0000;
      outstanding <= '0;
      tx_count    <= '0;
      rx_count    <= '0;
    end else begin
      slot <= ~slot;
      tag  <= {tag[LAT-2:0], accept};

      if (slot) begin
        link_data <= accept ? op_a : 16'h0000;
        if (accept) begin
          b_hold   <= op_b;
          tx_count <= tx_count + COUNT_W'(1);
        end
      end else begin
        link_data <= b_hold;
        b_hold    <= 16'h0000;
        hi_byte   <= link_byte;
      end

      if (deliver) begin
        res_data  <= {hi_byte, link_byte};
        res_valid <= 1'b1;
        rx_count  <= rx_count + COUNT_W'(1);
      end else begin
        res_valid <= 1'b0;
      end

      case ({accept, deliver})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_link_host.sv
// Directed bench for dlfloat_link_host: a cycle model of the link, a tile byte
// model returning scheduled results, and a COUNT_W=4 instance for counter wrap.
module tb_dlfloat_link_host;
  localparam int LAT = 6;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        op_valid = 1'b0;
  logic [15:0] op_a = 16'h0000;
  logic [15:0] op_b = 16'h0000;
  logic [7:0]  link_byte = 8'h00;
  logic        op_ready, res_valid, busy;
  logic [15:0] link_data, res_data, tx_count, rx_count;
  logic        w_ready, w_valid, w_busy;
  logic [15:0] w_link, w_data;
  logic [3:0]  w_tx, w_rx;

  int n_tests = 0;
  int n_fail  = 0;

  // cycle model state
  bit          m_slot;
  int          m_cyc, m_out, m_tx, m_rx;
  logic [15:0] m_link, m_bhold;
  bit          ev [DEPTH];
  logic [15:0] ed [DEPTH];
  logic [7:0]  bm [DEPTH];
  bit          ff_mode = 1'b0;
  logic        acc;

  always #5 clk = ~clk;

  dlfloat_link_host #(.LAT(LAT), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .link_data(link_data),
    .link_byte(link_byte), .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .tx_count(tx_count), .rx_count(rx_count)
  );

  dlfloat_link_host #(.LAT(LAT), .COUNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .op_ready(w_ready), .link_data(w_link),
    .link_byte(link_byte), .res_valid(w_valid), .res_data(w_data),
    .busy(w_busy), .tx_count(w_tx), .rx_count(w_rx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ev[i] = 1'b0;
      ed[i] = 16'h0000;
      bm[i] = 8'h00;
    end
    m_slot = 1'b0; m_cyc = 0; m_out = 0; m_tx = 0; m_rx = 0;
    m_link = 16'h0000; m_bhold = 16'h0000;
  endtask

  // one clock cycle: drive inputs, check op_ready, advance model, check outputs
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] r, input logic en, output logic accepted);
    logic exp_rdy, dlv;
    op_valid = v; op_a = a; op_b = b; enable = en;
    exp_rdy = en && m_slot && (m_out < LAT / 2);
    #1;
    chk("op_ready", {31'd0, op_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    accepted = v && exp_rdy;
    dlv = ev[m_cyc + 1];
    if (m_slot) begin
      m_link = accepted ? a : 16'h0000;
      if (accepted) begin
        m_bhold = b;
        m_tx++;
        ev[m_cyc + LAT + 1] = 1'b1;
        ed[m_cyc + LAT + 1] = r;
        bm[m_cyc + LAT - 1] = r[15:8];
        bm[m_cyc + LAT]     = r[7:0];
      end
    end else begin
      m_link  = m_bhold;
      m_bhold = 16'h0000;
    end
    if (dlv) m_rx++;
    m_out = m_out + (accepted ? 1 : 0) - (dlv ? 1 : 0);
    m_slot = !m_slot;
    m_cyc++;
    #1;
    link_byte = ff_mode ? 8'hFF : bm[m_cyc];
    chk("link_data", {16'd0, link_data}, {16'd0, m_link});
    chk("res_valid", {31'd0, res_valid}, {31'd0, ev[m_cyc]});
    if (ev[m_cyc]) chk("res_data", {16'd0, res_data}, {16'd0, ed[m_cyc]});
    chk("tx_count", {16'd0, tx_count}, m_tx[31:0] & 32'h0000FFFF);
    chk("rx_count", {16'd0, rx_count}, m_rx[31:0] & 32'h0000FFFF);
    chk("busy", {31'd0, busy}, {31'd0, (m_out != 0)});
  endtask

  task automatic idle(input int n, input logic en);
    logic a_ign;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000, 16'h0000, en, a_ign);
  endtask

  task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
    logic got;
    int k;
    got = 1'b0;
    k = 0;
    while (!got && k < 20) begin
      step(1'b1, a, b, r, 1'b1, got);
      k++;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; op_valid = 1'b0; enable = 1'b0; link_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_link_data", {16'd0, link_data}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_tx_count", {16'd0, tx_count}, 32'd0);
    chk("rst_rx_count", {16'd0, rx_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    // reset and idle
    do_reset();
    idle(20, 1'b1);

    // single pair, result 0xABCD
    offer(16'h3E00, 16'h4100, 16'hABCD);
    idle(LAT + 2, 1'b1);
    chk("single_tx", {16'd0, tx_count}, 32'd1);
    chk("single_rx", {16'd0, rx_count}, 32'd1);
    chk("single_data", {16'd0, res_data}, 32'h0000ABCD);

    // back-to-back, op_valid held until each pair is taken
    for (int i = 1; i <= 8; i++)
      offer(16'(i), 16'(i << 8), 16'hC000 | 16'(i));
    idle(LAT + 8, 1'b1);
    chk("b2b_rx", {16'd0, rx_count}, 32'd9);
    chk("b2b_last", {16'd0, res_data}, 32'h0000C008);

    // bubble filtering with a constant 0xFF byte stream
    ff_mode = 1'b1;
    link_byte = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      offer(16'h1111, 16'h2222, 16'hFFFF);
      idle(3, 1'b1);
    end
    idle(LAT + 4, 1'b1);
    chk("bubble_rx", {16'd0, rx_count}, 32'd13);
    ff_mode = 1'b0;

    // enable drop mid-flight
    offer(16'h0A0A, 16'h0B0B, 16'h1234);
    offer(16'h0C0C, 16'h0D0D, 16'h5678);
    idle(LAT + 4, 1'b0);
    chk("en_rx", {16'd0, rx_count}, 32'd15);
    chk("en_last", {16'd0, res_data}, 32'h00005678);

    // reset with two pairs in flight
    offer(16'h0E0E, 16'h0F0F, 16'h9999);
    offer(16'h1E1E, 16'h1F1F, 16'h8888);
    do_reset();
    idle(LAT + 6, 1'b1);
    chk("post_rst_rx", {16'd0, rx_count}, 32'd0);

    // 17 pairs for the 4-bit counter wrap
    for (int i = 0; i < 17; i++) offer(16'h4000 | 16'(i), 16'h5000 | 16'(i), 16'h6000 | 16'(i));
    idle(LAT + 6, 1'b1);
    chk("wrap_tx", {28'd0, w_tx}, 32'd1);
    chk("wrap_rx", {28'd0, w_rx}, 32'd1);
    chk("wide_tx", {16'd0, tx_count}, 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
